// File: rtl/sad_acc_min_if.sv
// SAD accumulator bus: row input, candidate vector and result signals.
// Pure wiring; no latency or backpressure of its own.
interface sad_acc_min_if #(
   parameter int NUM_PE = 8,
   parameter int PIXEL  = 8
);
   logic                      search_start;
   logic                      abs_valid;
   logic [NUM_PE*PIXEL-1:0]   abs_in;
   logic signed [4:0]         cand_mv_x;
   logic signed [4:0]         cand_mv_y;
   logic                      cand_last;
   logic                      sad_valid;
   logic [13:0]               sad_out;
   logic [13:0]               best_sad;
   logic signed [4:0]         best_mv_x;
   logic signed [4:0]         best_mv_y;
   logic                      busy;
   logic                      done;

   modport master (
      output search_start, abs_valid, abs_in, cand_mv_x, cand_mv_y, cand_last,
      input  sad_valid, sad_out, best_sad, best_mv_x, best_mv_y, busy, done
   );

   modport slave (
      input  search_start, abs_valid, abs_in, cand_mv_x, cand_mv_y, cand_last,
      output sad_valid, sad_out, best_sad, best_mv_x, best_mv_y, busy, done
   );
endinterface

// File: rtl/sad_acc_min.sv
// Per-candidate SAD accumulation over ROWS block rows with running-minimum search.
// Final row -> sad_valid 2 cycles later, best_* 3 cycles later; no backpressure.
module sad_acc_min #(
   parameter int NUM_PE = 8,
   parameter int ROWS   = 8,
   parameter int PIXEL  = 8
) (
   input  logic          clk,
   input  logic          rst,
   sad_acc_min_if.slave  bus
);
   localparam int SUM_W = PIXEL + $clog2(NUM_PE);
   localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
   state_t state, nxt;

   logic [SUM_W-1:0] lane_sum;
   logic [CNT_W-1:0] row_cnt, cnt_eff;
   logic             accept, first_in, final_in, last_in, cand_last_q;

   logic             row_vld, row_first, row_final, row_last;
   logic [SUM_W-1:0] row_sum;
   logic signed [4:0] row_mv_x, row_mv_y;

   logic [13:0]      acc, acc_nxt;
   logic signed [4:0] cand_mv_x_q, cand_mv_y_q;
   logic             sad_vld, sad_last;
   logic [13:0]      sad_q, best_sad_q;
   logic signed [4:0] best_mv_x_q, best_mv_y_q;
   logic             busy_q, done_q;

   always_comb begin
      lane_sum = '0;
      for (int l = 0; l < NUM_PE; l++)
         lane_sum = lane_sum + SUM_W'(bus.abs_in[l*PIXEL +: PIXEL]);
   end

   // A search_start row is row 0 of the new search regardless of stale counters.
   always_comb begin
      cnt_eff  = bus.search_start ? '0 : row_cnt;
      accept   = bus.abs_valid && (bus.search_start || state == RUN);
      first_in = (cnt_eff == '0);
      final_in = (cnt_eff == LAST_ROW);
      last_in  = first_in ? bus.cand_last : cand_last_q;
      acc_nxt  = row_first ? 14'(row_sum) : acc + 14'(row_sum);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      if (bus.search_start) begin
         nxt = RUN;
      end else begin
         case (state)
            IDLE:    nxt = IDLE;
            RUN:     if (accept && final_in && last_in) nxt = FLUSH;
            FLUSH:   if (sad_vld && sad_last) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_cnt     <= '0;
         cand_last_q <= 1'b0;
         row_vld     <= 1'b0;
         row_first   <= 1'b0;
         row_final   <= 1'b0;
         row_last    <= 1'b0;
         row_sum     <= '0;
         row_mv_x    <= '0;
         row_mv_y    <= '0;
         acc         <= '0;
         cand_mv_x_q <= '0;
         cand_mv_y_q <= '0;
         sad_vld     <= 1'b0;
         sad_last    <= 1'b0;
         sad_q       <= '0;
         best_sad_q  <= 14'h3FFF;
         best_mv_x_q <= '0;
         best_mv_y_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         // Stage 1: lane sum and per-row tags
         row_vld <= accept;
         if (accept) begin
            row_sum   <= lane_sum;
            row_first <= first_in;
            row_final <= final_in;
            row_last  <= last_in;
            row_mv_x  <= bus.cand_mv_x;
            row_mv_y  <= bus.cand_mv_y;
            row_cnt   <= final_in ? '0 : cnt_eff + CNT_W'(1);
            if (first_in) cand_last_q <= bus.cand_last;
         end else if (bus.search_start) begin
            row_cnt <= '0;
         end

         // Stage 2: accumulate; anything in flight at a search_start is dropped
         if (bus.search_start) begin
            acc     <= '0;
            sad_vld <= 1'b0;
         end else begin
            sad_vld <= row_vld && row_final;
            if (row_vld) begin
               acc <= acc_nxt;
               if (row_first) begin
                  cand_mv_x_q <= row_mv_x;
                  cand_mv_y_q <= row_mv_y;
               end
               if (row_final) begin
                  sad_q    <= acc_nxt;
                  sad_last <= row_last;
               end
            end
         end

         // Stage 3: strict compare keeps the earlier candidate on a tie
         if (bus.search_start) begin
            best_sad_q  <= 14'h3FFF;
            best_mv_x_q <= '0;
            best_mv_y_q <= '0;
         end else if (sad_vld && (sad_q < best_sad_q)) begin
            best_sad_q  <= sad_q;
            best_mv_x_q <= cand_mv_x_q;
            best_mv_y_q <= cand_mv_y_q;
         end

         busy_q <= (nxt == RUN) || (nxt == FLUSH);
         done_q <= (nxt == DONE);
      end
   end

   assign bus.sad_valid = sad_vld;
   assign bus.sad_out   = sad_q;
   assign bus.best_sad  = best_sad_q;
   assign bus.best_mv_x = best_mv_x_q;
   assign bus.best_mv_y = best_mv_y_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
endmodule

// File: tb/tb_sad_acc_min.sv
// Scenario tests for sad_acc_min; expected SADs queued at drive time, popped on sad_valid.
module tb_sad_acc_min;
   localparam int NUM_PE = 8;
   localparam int ROWS   = 8;
   localparam int PIXEL  = 8;
   typedef logic [NUM_PE*PIXEL-1:0] row_t;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   sb[$];

   sad_acc_min_if #(.NUM_PE(NUM_PE), .PIXEL(PIXEL)) bus ();

   sad_acc_min #(.NUM_PE(NUM_PE), .ROWS(ROWS), .PIXEL(PIXEL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!rst && bus.sad_valid === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sad_unexpected: sad_valid with sad_out=%0d, none expected", bus.sad_out);
         end else begin
            int exp_sad;
            exp_sad = sb.pop_front();
            if (bus.sad_out !== 14'(exp_sad)) begin
               errors++;
               $display("FAIL sad_out: got %0d expected %0d", bus.sad_out, exp_sad);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int row_total(input row_t r);
      int s = 0;
      for (int l = 0; l < NUM_PE; l++) s += int'(r[l*PIXEL +: PIXEL]);
      return s;
   endfunction

   function automatic row_t fill_row(input int v);
      row_t r;
      for (int l = 0; l < NUM_PE; l++) r[l*PIXEL +: PIXEL] = PIXEL'(v);
      return r;
   endfunction

   function automatic row_t rand_row();
      row_t r;
      for (int l = 0; l < NUM_PE; l++) r[l*PIXEL +: PIXEL] = PIXEL'($urandom_range(255, 0));
      return r;
   endfunction

   // Vector and cand_last are only meaningful on row 0; later rows carry decoys.
   task automatic send_cand(input row_t rows[ROWS], input int nrows,
                            input logic signed [4:0] mx, input logic signed [4:0] my,
                            input logic last, input logic start, input int max_gap,
                            input logic push, output int sad);
      sad = 0;
      for (int r = 0; r < nrows; r++) sad += row_total(rows[r]);
      if (push) sb.push_back(sad);
      for (int r = 0; r < nrows; r++) begin
         if (r > 0 && max_gap > 0) repeat ($urandom_range(max_gap, 1)) tick();
         bus.abs_valid    = 1'b1;
         bus.abs_in       = rows[r];
         bus.cand_mv_x    = (r == 0) ? mx : 5'sd15;
         bus.cand_mv_y    = (r == 0) ? my : -5'sd16;
         bus.cand_last    = (r == 0) ? last : ~last;
         bus.search_start = start && (r == 0);
         tick();
         bus.abs_valid    = 1'b0;
         bus.search_start = 1'b0;
         bus.cand_last    = 1'b0;
      end
   endtask

   task automatic start_pulse();
      bus.search_start = 1'b1;
      tick();
      bus.search_start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int exp_best,
                            input logic signed [4:0] ex, input logic signed [4:0] ey);
      bit seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s_done: done not seen within 40 cycles", name);
      end
      checks++;
      if (bus.best_sad !== 14'(exp_best) || bus.best_mv_x !== ex || bus.best_mv_y !== ey) begin
         errors++;
         $display("FAIL %s_best: got sad=%0d mv=(%0d,%0d) expected sad=%0d mv=(%0d,%0d)",
                  name, bus.best_sad, bus.best_mv_x, bus.best_mv_y, exp_best, ex, ey);
      end
      tick();
   endtask

   task automatic check_reset_values(input string name);
      checks++;
      if (bus.sad_valid !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.sad_out !== 14'd0) begin
         errors++;
         $display("FAIL %s_ctl: got sad_valid=%b done=%b busy=%b sad_out=%0d expected 0 0 0 0",
                  name, bus.sad_valid, bus.done, bus.busy, bus.sad_out);
      end
      checks++;
      if (bus.best_sad !== 14'h3FFF || bus.best_mv_x !== 5'sd0 || bus.best_mv_y !== 5'sd0) begin
         errors++;
         $display("FAIL %s_best: got sad=%0d mv=(%0d,%0d) expected 16383 (0,0)",
                  name, bus.best_sad, bus.best_mv_x, bus.best_mv_y);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_values("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_idle_ignore();
      row_t rows[ROWS];
      int   sad;
      for (int r = 0; r < ROWS; r++) rows[r] = fill_row(9);
      send_cand(rows, ROWS, 5'sd1, 5'sd1, 1'b1, 1'b0, 0, 1'b0, sad);
      repeat (4) tick();
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.best_sad !== 14'h3FFF) begin
         errors++;
         $display("FAIL idle_ignore: got busy=%b best_sad=%0d expected 0 16383", bus.busy, bus.best_sad);
      end
      tick();
   endtask

   task automatic test_single();
      row_t rows[ROWS];
      int   sad;
      for (int r = 0; r < ROWS; r++) rows[r] = fill_row(1);
      start_pulse();
      send_cand(rows, ROWS, 5'sd3, -5'sd2, 1'b1, 1'b0, 0, 1'b1, sad);
      @(negedge clk);
      checks++;
      if (bus.sad_valid !== 1'b0 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL single_t1: got sad_valid=%b busy=%b expected 0 1", bus.sad_valid, bus.busy);
      end
      @(negedge clk);
      checks++;
      if (bus.sad_valid !== 1'b1 || bus.best_sad !== 14'h3FFF) begin
         errors++;
         $display("FAIL single_t2: got sad_valid=%b best_sad=%0d expected 1 16383", bus.sad_valid, bus.best_sad);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.best_sad !== 14'd64 ||
          bus.best_mv_x !== 5'sd3 || bus.best_mv_y !== -5'sd2) begin
         errors++;
         $display("FAIL single_t3: got done=%b busy=%b best=%0d mv=(%0d,%0d) expected 1 0 64 (3,-2)",
                  bus.done, bus.busy, bus.best_sad, bus.best_mv_x, bus.best_mv_y);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0) begin
         errors++;
         $display("FAIL single_t4: done=%b expected 0 (one-cycle pulse)", bus.done);
      end
      tick();
   endtask

   task automatic test_min_tie();
      int   totals[3] = '{200, 150, 150};
      row_t rows[ROWS];
      int   sad;
      for (int c = 0; c < 3; c++) begin
         for (int r = 0; r < ROWS; r++) begin
            int v;
            v = (r == 0) ? totals[c] - (ROWS - 1) * (totals[c] / ROWS) : totals[c] / ROWS;
            rows[r] = '0;
            rows[r][PIXEL-1:0] = PIXEL'(v);
         end
         send_cand(rows, ROWS, 5'(c), 5'sd0, (c == 2), (c == 0), 0, 1'b1, sad);
      end
      wait_done("min_tie", 150, 5'sd1, 5'sd0);
   endtask

   task automatic test_max();
      row_t rows[ROWS];
      int   sad;
      for (int r = 0; r < ROWS; r++) rows[r] = fill_row(255);
      send_cand(rows, ROWS, -5'sd16, 5'sd15, 1'b1, 1'b1, 0, 1'b1, sad);
      wait_done("max", 16320, -5'sd16, 5'sd15);
   endtask

   // Same candidates gapless then gapped; the queue expects identical SADs both times.
   task automatic test_gaps();
      row_t cand[3][ROWS];
      int   sad, best;
      logic signed [4:0] bx, by;
      for (int c = 0; c < 3; c++)
         for (int r = 0; r < ROWS; r++) cand[c][r] = rand_row();
      for (int pass = 0; pass < 2; pass++) begin
         best = 16383; bx = 0; by = 0;
         for (int c = 0; c < 3; c++) begin
            send_cand(cand[c], ROWS, 5'(c - 4), 5'(c + 2), (c == 2), (c == 0),
                      pass * 3, 1'b1, sad);
            if (sad < best) begin
               best = sad; bx = 5'(c - 4); by = 5'(c + 2);
            end
         end
         wait_done(pass == 0 ? "gapless" : "gaps", best, bx, by);
      end
   endtask

   task automatic test_back_to_back();
      row_t rows[ROWS];
      int   sad, best;
      logic signed [4:0] bx, by;
      best = 16383; bx = 0; by = 0;
      for (int c = 0; c < 5; c++) begin
         for (int r = 0; r < ROWS; r++) rows[r] = rand_row();
         send_cand(rows, ROWS, 5'(c), -5'(c), (c == 4), (c == 0), 0, 1'b1, sad);
         if (sad < best) begin
            best = sad; bx = 5'(c); by = -5'(c);
         end
      end
      wait_done("b2b", best, bx, by);
   endtask

   task automatic test_abort();
      row_t rows[ROWS];
      int   sad;
      for (int r = 0; r < ROWS; r++) rows[r] = fill_row(5);
      send_cand(rows, 4, 5'sd7, 5'sd7, 1'b0, 1'b1, 0, 1'b0, sad);
      for (int r = 0; r < ROWS; r++) rows[r] = fill_row(0);
      send_cand(rows, ROWS, -5'sd3, 5'sd4, 1'b1, 1'b1, 0, 1'b1, sad);
      wait_done("abort", 0, -5'sd3, 5'sd4);
   endtask

   task automatic test_rst_flush();
      row_t rows[ROWS];
      int   sad;
      bit   bad;
      for (int r = 0; r < ROWS; r++) rows[r] = fill_row(2);
      send_cand(rows, ROWS, 5'sd2, 5'sd2, 1'b1, 1'b1, 0, 1'b0, sad);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_reset_values("rst_flush");
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad = 1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL rst_flush_quiet: done or busy asserted after reset in FLUSH");
      end
      tick();
   endtask

   initial begin
      rst              = 1'b1;
      bus.search_start = 1'b0;
      bus.abs_valid    = 1'b0;
      bus.abs_in       = '0;
      bus.cand_mv_x    = '0;
      bus.cand_mv_y    = '0;
      bus.cand_last    = 1'b0;
      test_reset();
      test_idle_ignore();
      test_single();
      test_min_tie();
      test_max();
      test_gaps();
      test_back_to_back();
      test_abort();
      test_rst_flush();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d expected SADs never produced, expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
